// File: rtl/xalu_md_if.sv
// Issue/result bundle between the E stage and the multiply/divide unit.
// The master side drives the issue fields; the slave side returns status and results.
interface xalu_md_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] rd_out;

    modport master (
        output start, op, a, b, flush,
        input  busy, hi, lo, rd_out
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, hi, lo, rd_out
    );
endinterface

// File: rtl/xalu_md.sv
// Multi-cycle multiply/divide unit owning HI/LO, with multiply-accumulate and flush support.
// Operands are captured at issue; the result is committed on the last busy cycle's edge.
module xalu_md #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    xalu_md_if.slave   bus
);
    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_op;
    logic             r_signed;

    logic               w_isMul;
    logic               w_isDiv;
    logic               w_startSigned;
    logic               w_rIsDiv;
    logic               w_rIsAdd;
    logic               w_rIsSub;
    logic               w_divZero;
    logic               w_aNeg;
    logic               w_bNeg;
    logic [2*WIDTH-1:0] w_aExt;
    logic [2*WIDTH-1:0] w_bExt;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_acc;
    logic [2*WIDTH-1:0] w_res;
    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    always_comb begin
        w_isMul       = bus.op inside {4'd1, 4'd2, 4'd7, 4'd8, 4'd9, 4'd10};
        w_isDiv       = bus.op inside {4'd3, 4'd4};
        w_startSigned = bus.op inside {4'd1, 4'd3, 4'd7, 4'd9};
        w_rIsDiv      = r_op inside {4'd3, 4'd4};
        w_rIsAdd      = r_op inside {4'd7, 4'd8};
        w_rIsSub      = r_op inside {4'd9, 4'd10};
    end

    // Sign-extending to 2*WIDTH lets one unsigned multiplier serve both signednesses.
    always_comb begin
        w_aExt = r_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
        w_bExt = r_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
        w_prod = w_aExt * w_bExt;
        w_acc  = {r_hi, r_lo};
    end

    // Divide magnitudes, then restore signs; a zero divisor is replaced to keep results defined.
    always_comb begin
        w_divZero = (r_b == '0);
        w_aNeg    = r_signed & r_a[WIDTH-1];
        w_bNeg    = r_signed & r_b[WIDTH-1];
        w_magA    = w_aNeg ? -r_a : r_a;
        w_magB    = w_divZero ? {{(WIDTH-1){1'b0}}, 1'b1} : (w_bNeg ? -r_b : r_b);
        w_q       = w_magA / w_magB;
        w_r       = w_magA % w_magB;
        w_quo     = (w_aNeg ^ w_bNeg) ? -w_q : w_q;
        w_rem     = w_aNeg ? -w_r : w_r;
    end

    always_comb begin
        w_res = w_prod;
        if (w_rIsDiv) begin
            w_res = {w_rem, w_quo};
        end else if (w_rIsAdd) begin
            w_res = w_acc + w_prod;
        end else if (w_rIsSub) begin
            w_res = w_acc - w_prod;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_signed <= 1'b0;
        end else if (bus.flush) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (w_isMul || w_isDiv) begin
                            r_a      <= bus.a;
                            r_b      <= bus.b;
                            r_op     <= bus.op;
                            r_signed <= w_startSigned;
                            r_cnt    <= w_isDiv ? DIV_LOAD : MULT_LOAD;
                            r_state  <= RUN;
                            r_busy   <= 1'b1;
                        end else if (bus.op == 4'd5) begin
                            r_hi <= bus.a;
                        end else if (bus.op == 4'd6) begin
                            r_lo <= bus.a;
                        end
                    end
                end
                RUN: begin
                    if (r_cnt == '0) begin
                        if (!(w_rIsDiv && w_divZero)) begin
                            {r_hi, r_lo} <= w_res;
                        end
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.hi     = r_hi;
    assign bus.lo     = r_lo;
    assign bus.rd_out = (bus.op == 4'd11) ? r_hi : ((bus.op == 4'd12) ? r_lo : '0);
endmodule

// File: tb/tb_xalu_md.sv
// Scoreboard bench for xalu_md: stimulus pushes expected HI/LO and busy length per operation,
// and a monitor per instance checks them when busy falls.
module tb_xalu_md;
    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    exp_t exp32[$];
    exp_t exp16[$];

    xalu_md_if #(.WIDTH(32)) if32 ();
    xalu_md_if #(.WIDTH(16)) if16 ();

    xalu_md #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u32 (
        .clk   (clk),
        .reset (reset),
        .bus   (if32.slave)
    );

    xalu_md #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(10)) u16 (
        .clk   (clk),
        .reset (reset),
        .bus   (if16.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if32.start = 1'b1;
        if32.op    = op;
        if32.a     = a;
        if32.b     = b;
        @(posedge clk);
        #1;
        if32.start = 1'b0;
        if32.op    = 4'd0;
        if32.a     = $urandom;
        if32.b     = $urandom;
    endtask

    task automatic applyStimulus16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        if16.start = 1'b1;
        if16.op    = op;
        if16.a     = a;
        if16.b     = b;
        @(posedge clk);
        #1;
        if16.start = 1'b0;
        if16.op    = 4'd0;
        if16.a     = 16'(unsigned'($urandom));
        if16.b     = 16'(unsigned'($urandom));
    endtask

    task automatic pushExp(input bit is16, input string name, input logic [31:0] hi,
                           input logic [31:0] lo, input int cycles);
        exp_t e;
        e.name   = name;
        e.hi     = hi;
        e.lo     = lo;
        e.cycles = cycles;
        if (is16) exp16.push_back(e);
        else      exp32.push_back(e);
    endtask

    task automatic waitIdle(input bit is16);
        int n = 0;
        while (((is16 ? if16.busy : if32.busy) === 1'b1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("[TB] FAIL waitIdle: busy still 1 after %0d cycles, expected 0", n);
        end
    endtask

    // Completion monitors: a busy 1->0 transition marks the end of an operation.
    bit   prevBusy32 = 1'b0;
    int   busyCnt32  = 0;
    exp_t e32;
    always @(negedge clk) begin
        if (if32.busy === 1'b1) begin
            busyCnt32++;
        end else if (prevBusy32) begin
            if (exp32.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected32: completion with hi=0x%08h lo=0x%08h, expected none",
                         if32.hi, if32.lo);
            end else begin
                e32 = exp32.pop_front();
                checkOutput({e32.name, " hi"}, if32.hi, e32.hi);
                checkOutput({e32.name, " lo"}, if32.lo, e32.lo);
                checkOutput({e32.name, " busy cycles"}, 32'(busyCnt32), 32'(e32.cycles));
            end
            busyCnt32 = 0;
        end
        prevBusy32 = (if32.busy === 1'b1);
    end

    bit   prevBusy16 = 1'b0;
    int   busyCnt16  = 0;
    exp_t e16;
    always @(negedge clk) begin
        if (if16.busy === 1'b1) begin
            busyCnt16++;
        end else if (prevBusy16) begin
            if (exp16.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected16: completion with hi=0x%04h lo=0x%04h, expected none",
                         if16.hi, if16.lo);
            end else begin
                e16 = exp16.pop_front();
                checkOutput({e16.name, " hi"}, {16'h0, if16.hi}, e16.hi);
                checkOutput({e16.name, " lo"}, {16'h0, if16.lo}, e16.lo);
                checkOutput({e16.name, " busy cycles"}, 32'(busyCnt16), 32'(e16.cycles));
            end
            busyCnt16 = 0;
        end
        prevBusy16 = (if16.busy === 1'b1);
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        if32.start = 1'b0;
        if32.op    = 4'd0;
        if32.a     = '0;
        if32.b     = '0;
        if32.flush = 1'b0;
        if16.start = 1'b0;
        if16.op    = 4'd0;
        if16.a     = '0;
        if16.b     = '0;
        if16.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        checkOutput("reset busy", {31'h0, if32.busy}, 32'h0);
        checkOutput("reset hi", if32.hi, 32'h0);
        checkOutput("reset lo", if32.lo, 32'h0);

        applyStimulus(4'd5, 32'h12345678, 32'h0);
        applyStimulus(4'd6, 32'h9ABCDEF0, 32'h0);
        checkOutput("mthi hi", if32.hi, 32'h12345678);
        checkOutput("mtlo lo", if32.lo, 32'h9ABCDEF0);
        checkOutput("mthi/mtlo busy", {31'h0, if32.busy}, 32'h0);
        if32.op = 4'd11;
        #1;
        checkOutput("mfhi rd_out", if32.rd_out, 32'h12345678);
        if32.op = 4'd12;
        #1;
        checkOutput("mflo rd_out", if32.rd_out, 32'h9ABCDEF0);
        if32.op = 4'd0;
        #1;
        checkOutput("no-op rd_out", if32.rd_out, 32'h0);

        pushExp(0, "mult -2*3", 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        applyStimulus(4'd1, 32'hFFFFFFFE, 32'd3);
        waitIdle(0);
        pushExp(0, "multu", 32'h00000002, 32'hFFFFFFFA, 5);
        applyStimulus(4'd2, 32'hFFFFFFFE, 32'd3);
        waitIdle(0);
        pushExp(0, "div -7/2", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        applyStimulus(4'd3, 32'hFFFFFFF9, 32'd2);
        waitIdle(0);
        pushExp(0, "div overflow", 32'h00000000, 32'h80000000, 10);
        applyStimulus(4'd3, 32'h80000000, 32'hFFFFFFFF);
        waitIdle(0);
        pushExp(0, "divu by zero", 32'h00000000, 32'h80000000, 10);
        applyStimulus(4'd4, 32'd5, 32'd0);
        waitIdle(0);

        applyStimulus(4'd5, 32'd0, 32'd0);
        applyStimulus(4'd6, 32'd10, 32'd0);
        pushExp(0, "madd", 32'h00000000, 32'd22, 5);
        applyStimulus(4'd7, 32'd3, 32'd4);
        waitIdle(0);
        pushExp(0, "msub", 32'hFFFFFFFF, 32'hFFFFFFFD, 5);
        applyStimulus(4'd9, 32'd5, 32'd5);
        waitIdle(0);
        pushExp(0, "maddu", 32'h00000001, 32'hFFFFFFFB, 5);
        applyStimulus(4'd8, 32'hFFFFFFFF, 32'd2);
        waitIdle(0);
        pushExp(0, "msubu", 32'h00000001, 32'h00000000, 5);
        applyStimulus(4'd10, 32'd1, 32'hFFFFFFFB);
        waitIdle(0);

        // Flush on the third busy cycle, with a competing mthi that must be dropped.
        pushExp(0, "flushed mult", 32'h00000001, 32'h00000000, 3);
        applyStimulus(4'd1, 32'd6, 32'd7);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        if32.flush = 1'b1;
        if32.start = 1'b1;
        if32.op    = 4'd5;
        if32.a     = 32'h0000DEAD;
        @(posedge clk);
        #1;
        if32.flush = 1'b0;
        if32.start = 1'b0;
        if32.op    = 4'd0;
        checkOutput("flush busy", {31'h0, if32.busy}, 32'h0);
        @(negedge clk);

        pushExp(0, "mult ignores start while busy", 32'h0, 32'd6, 5);
        applyStimulus(4'd1, 32'd2, 32'd3);
        if32.start = 1'b1;
        if32.op    = 4'd6;
        if32.a     = 32'h55;
        @(posedge clk);
        #1;
        if32.op = 4'd1;
        if32.a  = 32'd9;
        if32.b  = 32'd9;
        @(posedge clk);
        #1;
        if32.start = 1'b0;
        if32.op    = 4'd0;
        waitIdle(0);
        pushExp(0, "multu in first idle cycle", 32'h0, 32'd20, 5);
        applyStimulus(4'd2, 32'd4, 32'd5);
        waitIdle(0);

        pushExp(0, "reset mid-divide", 32'h0, 32'h0, 4);
        applyStimulus(4'd3, 32'd100, 32'd7);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        checkOutput("reset mid-divide busy", {31'h0, if32.busy}, 32'h0);
        @(negedge clk);

        pushExp(1, "mult16 0x8000^2", 32'h00004000, 32'h00000000, 1);
        applyStimulus16(4'd1, 16'h8000, 16'h8000);
        waitIdle(1);
        pushExp(1, "multu16 0xFFFF^2", 32'h0000FFFE, 32'h00000001, 1);
        applyStimulus16(4'd2, 16'hFFFF, 16'hFFFF);
        waitIdle(1);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard32 drained", 32'(exp32.size()), 32'h0);
        checkOutput("scoreboard16 drained", 32'(exp16.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/xalu_md.md
Name: xalu_md

Overview:
- Parametrised multiply/divide unit for the E stage of the pipelined core; successor to the fixed-width, fixed-latency XALU.
- Adds configurable datapath width and per-operation latency, multiply-accumulate/subtract (madd, maddu, msub, msubu) and a flush input that aborts an in-flight operation.
- Owns the HI/LO registers. The hazard unit stalls D while `busy` is high or `start` is high with an md-class op.

Parameters:
- WIDTH, 32: operand and HI/LO width; WIDTH >= 8.
- MULT_CYCLES, 5: busy cycles for mult/multu/madd/maddu/msub/msubu; >= 1.
- DIV_CYCLES, 10: busy cycles for div/divu; >= 1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- start  in  1  issue strobe, qualified with op
- op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu, 11 mfhi, 12 mflo; 13-15 no-op
- a  in  WIDTH  rs operand
- b  in  WIDTH  rt operand
- flush  in  1  abort the in-flight operation
- busy  out  1  registered; high while an operation is in flight
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- rd_out  out  WIDTH  combinational: hi when op=11, lo when op=12, else 0

Behaviour:
- Reset (reset==0 at a rising edge): hi=0, lo=0, busy=0, state IDLE, counter=0. Reset overrides start and flush, and cancels any in-flight operation.
- States: IDLE and RUN. A down-counter is sized for max(MULT_CYCLES, DIV_CYCLES).
- IDLE, start=1, op in {1,2,3,4,7-10}, flush=0:
  - Latch a, b, op and the operands' sign interpretation.
  - Load counter with N-1, where N is MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; busy=1 from the next cycle.
- RUN:
  - Decrement counter each cycle.
  - On the edge where the counter is 0, write the result to hi/lo, go to IDLE and clear busy.
  - busy is therefore high for exactly N cycles. New hi/lo are visible in the first cycle with busy=0.
- mthi/mtlo (op 5/6), start=1 in IDLE: hi<=a (or lo<=a) at that edge; busy stays 0.
- start=1 while busy=1 or in RUN: ignored, all ops including mthi/mtlo. Upstream stall guarantees this does not happen; it is a defensive rule.
- mfhi/mflo: purely combinational read of the current registers. No state change; busy not raised.
- Arithmetic:
  - mult/multu: signed/unsigned 2*WIDTH product; {hi,lo} <= product.
  - madd(u): {hi,lo} <= {hi,lo} + product.
  - msub(u): {hi,lo} <= {hi,lo} - product.
  - For all accumulate ops, wrap modulo 2^(2*WIDTH), and use the {hi,lo} value current at the completion edge.
  - div: lo <= quotient truncated toward zero, hi <= remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Divisor 0 (div/divu): the full busy period is spent and hi/lo are left unchanged.
  - Signed overflow (a = most negative, b = -1): lo <= most negative, hi <= 0.
- flush=1 at an edge:
  - Any RUN operation is discarded. State goes to IDLE, busy=0 next cycle, hi/lo keep their pre-operation values.
  - A simultaneous start is ignored, mthi/mtlo included.
  - flush in IDLE with start=0 has no effect.
  - flush on the completion edge: the result is discarded.
- Operands sampled at start are held internally; later changes to a and b do not affect the result.
- No back-to-back gap is required: start may be accepted in the first cycle busy=0.

Test Plan:
- Reset (reset=0 one cycle) then mthi a=0x12345678, then mtlo a=0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0, busy=0 throughout; mfhi/mflo rd_out match.
- mult a=0xFFFFFFFE (-2), b=3 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; multu same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div a=-7 (0xFFFFFFF9), b=2 -> busy high 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; div a=0x80000000, b=-1 -> lo=0x80000000, hi=0; divu b=0 -> hi/lo unchanged.
- mthi 0, mtlo 10, then madd a=3 b=4 -> lo=22, hi=0; then msub a=5 b=5 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- mult a=6 b=7 with flush=1 on the 3rd busy cycle -> busy=0 next cycle, hi/lo keep prior values; a start issued during busy is ignored; a start in the first idle cycle is accepted.
- reset=0 mid-divide (4th busy cycle) -> busy=0, hi=lo=0 next cycle; re-run with WIDTH=16, MULT_CYCLES=1: mult a=0x8000 b=0x8000 -> busy 1 cycle, hi=0x4000, lo=0x0000.
